// File: rtl/sigmoid_backward_if.sv
// Request/response bundle for sigmoid_backward: one valid/ready channel in, one out.
// A beat transfers on a rising clock edge where valid and ready are both high; ready may depend on state only.
interface sigmoid_backward_if #(
  parameter int DATA_BITS = 16,
  parameter int TAG_BITS  = 4
);
  logic                 in_valid;
  logic                 in_ready;
  logic [DATA_BITS-1:0] in_s;
  logic [DATA_BITS-1:0] in_g;
  logic [TAG_BITS-1:0]  in_tag;
  logic                 out_valid;
  logic                 out_ready;
  logic [DATA_BITS-1:0] out_grad;
  logic [TAG_BITS-1:0]  out_tag;

  modport master (
    output in_valid, in_s, in_g, in_tag, out_ready,
    input  in_ready, out_valid, out_grad, out_tag
  );

  modport slave (
    input  in_valid, in_s, in_g, in_tag, out_ready,
    output in_ready, out_valid, out_grad, out_tag
  );
endinterface

// File: rtl/sigmoid_backward.sv
// Sigmoid backward gradient g * s * (1 - s) in signed Q8.8, computed with one shared
// multiplier over a 4-state sequence; the captured tag is returned with the result.
module sigmoid_backward #(
  parameter int DATA_BITS = 16,
  parameter int FRAC_BITS = 8,
  parameter int TAG_BITS  = 4
) (
  input  logic               clock,
  input  logic               reset,
  sigmoid_backward_if.slave  bus,
  output logic [1:0]         state_dbg
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] MUL_D = 2'd1;
  localparam logic [1:0] MUL_G = 2'd2;
  localparam logic [1:0] OUT   = 2'd3;

  localparam logic signed [DATA_BITS-1:0] ONE = DATA_BITS'(1) << FRAC_BITS;

  logic [1:0]                    state;
  logic signed [DATA_BITS-1:0]   s_r;
  logic signed [DATA_BITS-1:0]   g_r;
  logic signed [DATA_BITS-1:0]   d_r;
  logic [TAG_BITS-1:0]           tag_r;
  logic signed [DATA_BITS-1:0]   s_clamp;
  logic signed [DATA_BITS-1:0]   mul_a;
  logic signed [DATA_BITS-1:0]   mul_b;
  logic signed [2*DATA_BITS-1:0] prod;
  logic signed [DATA_BITS-1:0]   prod_q;
  logic                          prod_unused;
  logic                          out_valid_r;
  logic [DATA_BITS-1:0]          out_grad_r;
  logic [TAG_BITS-1:0]           out_tag_r;

  always_comb begin
    s_clamp = $signed(bus.in_s);
    if ($signed(bus.in_s) < 0) begin
      s_clamp = '0;
    end else if ($signed(bus.in_s) > ONE) begin
      s_clamp = ONE;
    end
  end

  // Single multiplier: s*(1-s) in MUL_D, g*d otherwise.
  always_comb begin
    mul_a = g_r;
    mul_b = d_r;
    if (state == MUL_D) begin
      mul_a = s_r;
      mul_b = ONE - s_r;
    end
  end

  assign prod        = mul_a * mul_b;
  assign prod_q      = prod[DATA_BITS+FRAC_BITS-1:FRAC_BITS];
  assign prod_unused = ^{prod[2*DATA_BITS-1:DATA_BITS+FRAC_BITS], prod[FRAC_BITS-1:0]};

  // out_grad settles on entry to OUT; out_valid rises one cycle later.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      s_r         <= '0;
      g_r         <= '0;
      d_r         <= '0;
      tag_r       <= '0;
      out_valid_r <= 1'b0;
      out_grad_r  <= '0;
      out_tag_r   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            s_r   <= s_clamp;
            g_r   <= $signed(bus.in_g);
            tag_r <= bus.in_tag;
            state <= MUL_D;
          end
        end
        MUL_D: begin
          d_r   <= prod_q;
          state <= MUL_G;
        end
        MUL_G: begin
          out_grad_r <= prod_q;
          out_tag_r  <= tag_r;
          state      <= OUT;
        end
        OUT: begin
          if (!out_valid_r) begin
            out_valid_r <= 1'b1;
          end else if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = out_valid_r;
  assign bus.out_grad  = out_grad_r;
  assign bus.out_tag   = out_tag_r;
  assign state_dbg     = state;
endmodule

// File: tb/tb_sigmoid_backward.sv
// Directed bench for sigmoid_backward: driver tasks push hand-computed results into a
// queue, and an output monitor pops and compares them, also checking latency and hold.
module tb_sigmoid_backward;
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  sigmoid_backward_if #(.DATA_BITS(16), .TAG_BITS(4)) bus ();
  logic [1:0] state_dbg;

  sigmoid_backward #(.DATA_BITS(16), .FRAC_BITS(8), .TAG_BITS(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  logic [19:0] exp_q[$];
  int          acc_q[$];
  int          last_hs = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Output monitor, sampling just after the falling edge.
  initial begin
    logic        prev_v;
    logic [15:0] hg;
    logic [3:0]  ht;
    logic [19:0] e;
    int          a;
    prev_v = 1'b0;
    hg = '0;
    ht = '0;
    forever begin
      @(negedge clock);
      #1;
      if (reset && bus.out_valid) begin
        check("in_ready_while_out_valid", bus.in_ready, 0);
        if (!prev_v) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got grad 0x%0h tag 0x%0h, required no output", bus.out_grad, bus.out_tag);
          end else begin
            e = exp_q.pop_front();
            a = acc_q.pop_front();
            check("grad", bus.out_grad, e[15:0]);
            check("tag", bus.out_tag, e[19:16]);
            check("latency", cyc - a, 3);
          end
          hg = bus.out_grad;
          ht = bus.out_tag;
        end else begin
          check("grad_stable", bus.out_grad, hg);
          check("tag_stable", bus.out_tag, ht);
        end
        if (bus.out_ready) last_hs = cyc + 1;
      end
      prev_v = reset && bus.out_valid && !bus.out_ready;
    end
  end

  // Called at a falling edge; returns at the falling edge after the accept edge.
  task automatic send(input logic [15:0] s, input logic [15:0] g, input logic [3:0] tag,
                      input logic [15:0] exp, input bit keep, output int acc);
    int n;
    bus.in_valid = 1'b1;
    bus.in_s     = s;
    bus.in_g     = g;
    bus.in_tag   = tag;
    n = 0;
    while (!bus.in_ready && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready stayed 0, required 1 within 100 cycles");
      bus.in_valid = 1'b0;
      acc = -1;
      return;
    end
    exp_q.push_back({tag, exp});
    acc = cyc + 1;
    acc_q.push_back(acc);
    @(negedge clock);
    if (!keep) bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
      exp_q.delete();
      acc_q.delete();
    end
    @(negedge clock);
  endtask

  logic [15:0] st_s[8]   = '{16'h0080, 16'h00C0, 16'h0040, 16'h0100, 16'h0080, 16'h0080, 16'h0080, 16'h0010};
  logic [15:0] st_g[8]   = '{16'h0100, 16'hFF00, 16'h0100, 16'h1234, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h0100};
  logic [15:0] st_exp[8] = '{16'h0040, 16'hFFD0, 16'h0030, 16'h0000, 16'hFFFF, 16'h1FFF, 16'hE000, 16'h000F};

  initial begin
    int acc;
    int acc2;
    int n;
    bus.in_valid  = 1'b0;
    bus.in_s      = '0;
    bus.in_g      = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b1;

    repeat (3) @(negedge clock);
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_out_grad", bus.out_grad, 0);
    check("reset_out_tag", bus.out_tag, 0);
    check("reset_state", state_dbg, 0);
    reset = 1'b1;
    @(negedge clock);
    check("in_ready_after_reset", bus.in_ready, 1);

    send(16'h0080, 16'h0100, 4'h5, 16'h0040, 1'b0, acc);
    wait_drain();
    send(16'h00C0, 16'hFF00, 4'h1, 16'hFFD0, 1'b0, acc);
    wait_drain();

    send(16'h0200, 16'h7FFF, 4'h2, 16'h0000, 1'b0, acc);
    wait_drain();
    send(16'hFF80, 16'h7FFF, 4'h3, 16'h0000, 1'b0, acc);
    wait_drain();
    send(16'h0000, 16'h1234, 4'h4, 16'h0000, 1'b0, acc);
    wait_drain();

    // Backpressure with a second request waiting.
    bus.out_ready = 1'b0;
    send(16'h0080, 16'h0200, 4'h6, 16'h0080, 1'b0, acc);
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("bp_out_valid_seen", bus.out_valid, 1);
    bus.in_valid = 1'b1;
    bus.in_s     = 16'h00C0;
    bus.in_g     = 16'h0100;
    bus.in_tag   = 4'h7;
    repeat (5) begin
      @(negedge clock);
      check("bp_in_ready_low", bus.in_ready, 0);
      check("bp_out_valid_held", bus.out_valid, 1);
    end
    bus.out_ready = 1'b1;
    send(16'h00C0, 16'h0100, 4'h7, 16'h0030, 1'b0, acc2);
    check("bp_accept_after_handshake", acc2, last_hs + 1);
    wait_drain();

    // Stream with in_valid and out_ready held high.
    for (int i = 0; i < 8; i++) begin
      send(st_s[i], st_g[i], 4'(i + 8), st_exp[i], (i < 7), acc);
      if (i > 0) check("stream_accept_after_handshake", acc, last_hs + 1);
      if (i < 7) begin
        n = 0;
        while (!(bus.out_valid && bus.out_ready) && n < 20) begin
          @(negedge clock);
          n++;
        end
      end
    end
    wait_drain();

    // Asynchronous reset while in MUL_G.
    send(16'h0080, 16'h0100, 4'h9, 16'h0040, 1'b0, acc);
    @(posedge clock);
    #2;
    reset = 1'b0;
    void'(exp_q.pop_back());
    void'(acc_q.pop_back());
    #1;
    check("async_reset_out_valid", bus.out_valid, 0);
    check("async_reset_out_grad", bus.out_grad, 0);
    check("async_reset_out_tag", bus.out_tag, 0);
    check("async_reset_state", state_dbg, 0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("in_ready_after_async_reset", bus.in_ready, 1);
    repeat (8) begin
      @(negedge clock);
      check("no_stale_output", bus.out_valid, 0);
    end

    send(16'h0040, 16'h0100, 4'hA, 16'h0030, 1'b0, acc);
    wait_drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end
endmodule
